// File: rtl/mac_share_pkg.sv
// Shared types, default sizes and round-robin helpers for the shared multiply-add arbiter.
package mac_share_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 4;
  localparam int LAT_DEF   = 3;
  localparam int MAX_REQ   = 8;
  localparam int PTR_W     = $clog2(MAX_REQ);
  localparam int TAG_W     = $clog2(N_REQ_DEF);

  function automatic logic [MAX_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [MAX_REQ-1:0] o;
    o      = '0;
    o[idx] = 1'b1;
    return o;
  endfunction

  // Unused upper request bits are zero, so wrapping mod MAX_REQ equals wrapping mod N_REQ.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr);
    logic [MAX_REQ-1:0] g;
    logic               found;
    logic [PTR_W-1:0]   idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = ptr + PTR_W'(i);
      if (!found && valid[idx]) begin
        g     = onehot(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mac_share_arbiter_if.sv
// Requester/response bundle between the engines and the shared multiply-add arbiter.
interface mac_share_arbiter_if
  import mac_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
);
  logic               stall;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ*W-1:0] req_c;
  logic [N_REQ-1:0]   rsp_valid;
  logic [2*W-1:0]     rsp_data;
  logic               busy;

  modport master (
    output stall, req_valid, req_a, req_b, req_c,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  stall, req_valid, req_a, req_b, req_c,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/mac_pipe.sv
// Pipelined r = a*b + c with LAT register stages sharing one enable; the output
// register only loads when a valid op reaches it, so the result holds otherwise.
(* syn_multstyle = "logic" *)
module mac_pipe
  import mac_share_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           out_load,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   c,
  output logic [2*W-1:0] r
);

  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   c_r;
  logic [2*W-1:0] prod_s;
  logic [2*W-1:0] src_s;
  logic [2*W-1:0] res_r;

  // operand capture stage
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      c_r <= '0;
    end else if (en) begin
      a_r <= a;
      b_r <= b;
      c_r <= c;
    end
  end

  assign prod_s = ((2*W)'(a_r) * (2*W)'(b_r)) + (2*W)'(c_r);

  if (LAT == 2) begin : g_direct
    assign src_s = prod_s;
  end else begin : g_mid
    logic [2*W-1:0] mid_r [LAT-2];

    // product/addend stage followed by balancing delay stages
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < LAT - 2; k++) mid_r[k] <= '0;
      end else if (en) begin
        mid_r[0] <= prod_s;
        for (int k = 1; k < LAT - 2; k++) mid_r[k] <= mid_r[k-1];
      end
    end

    assign src_s = mid_r[LAT-3];
  end

  // output register, loaded only by a valid op
  always_ff @(posedge clk) begin
    if (rst) begin
      res_r <= '0;
    end else if (en && out_load) begin
      res_r <= src_s;
    end
  end

  assign r = res_r;

endmodule

// File: rtl/mac_share_arbiter.sv
// Round-robin sharing of one multiply-add pipe among N_REQ requesters, with the
// requester ID carried as a tag so each result is strobed back to its issuer.
module mac_share_arbiter
  import mac_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  parameter int LAT   = LAT_DEF
) (
  input logic               clk,
  input logic               rst,
  mac_share_arbiter_if.slave bus
);

  localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(LAT + 1);

  logic [TW-1:0]    ptr_r;
  logic [N_REQ-1:0] grant_s;
  logic [TW-1:0]    win_s;
  logic             hs_s;
  logic [W-1:0]     a_sel_s;
  logic [W-1:0]     b_sel_s;
  logic [W-1:0]     c_sel_s;
  logic [TW-1:0]    tag_sr [LAT-1];
  logic [LAT-2:0]   tvalid_sr;
  logic [N_REQ-1:0] rsp_valid_r;
  logic [N_REQ-1:0] rsp_next_s;
  logic [CW-1:0]    cnt_r;
  logic             dec_s;

  // grant: first valid at or after the pointer; nothing while stalled or in reset
  always_comb begin
    grant_s = '0;
    if (rst || bus.stall) begin
      grant_s = '0;
    end else begin
      grant_s = N_REQ'(rr_pick(MAX_REQ'(bus.req_valid), PTR_W'(ptr_r)));
    end
  end

  // encode the one-hot grant into the winner index
  always_comb begin
    win_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s[i]) begin
        win_s = TW'(i);
      end else begin
        win_s = win_s;
      end
    end
  end

  assign hs_s          = |(bus.req_valid & grant_s);
  assign a_sel_s       = bus.req_a[int'(win_s)*W +: W];
  assign b_sel_s       = bus.req_b[int'(win_s)*W +: W];
  assign c_sel_s       = bus.req_c[int'(win_s)*W +: W];
  assign bus.req_ready = grant_s;

  // round-robin pointer moves past the winner on each handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (hs_s) begin
      ptr_r <= (win_s == TW'(N_REQ - 1)) ? '0 : win_s + TW'(1);
    end
  end

  // tag/valid travel beside the pipe; the response register is the final stage
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_sr <= '0;
      for (int k = 0; k < LAT - 1; k++) tag_sr[k] <= '0;
    end else if (!bus.stall) begin
      tvalid_sr[0] <= hs_s;
      tag_sr[0]    <= win_s;
      for (int k = 1; k < LAT - 1; k++) begin
        tvalid_sr[k] <= tvalid_sr[k-1];
        tag_sr[k]    <= tag_sr[k-1];
      end
    end
  end

  assign rsp_next_s = tvalid_sr[LAT-2] ? N_REQ'(onehot(PTR_W'(tag_sr[LAT-2]))) : '0;

  // response strobe register, frozen with the datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= '0;
    end else if (!bus.stall) begin
      rsp_valid_r <= rsp_next_s;
    end
  end

  assign dec_s = (|rsp_valid_r) && !bus.stall;

  // in-flight counter: accepted ops not yet delivered
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else begin
      case ({hs_s, dec_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign bus.busy      = (cnt_r != '0);
  assign bus.rsp_valid = rsp_valid_r;

  mac_pipe #(
    .W   (W),
    .LAT (LAT)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (!bus.stall),
    .out_load (tvalid_sr[LAT-2]),
    .a        (a_sel_s),
    .b        (b_sel_s),
    .c        (c_sel_s),
    .r        (bus.rsp_data)
  );

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed + random bench for mac_share_arbiter with a response scoreboard.
module tb_mac_share_arbiter;
  import mac_share_pkg::*;

  localparam int N   = 4;
  localparam int WD  = 4;
  localparam int LT  = 3;

  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   ptr_m;
  int   inflight;
  int   ucnt;
  logic [7:0] last_data;
  exp_t q[$];

  mac_share_arbiter_if #(.N_REQ(N), .W(WD)) bus ();

  mac_share_arbiter #(.N_REQ(N), .W(WD), .LAT(LT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model_grant(input logic [3:0] v, input int p);
    logic [3:0] g;
    logic       found;
    int         j;
    g     = 4'b0000;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (!found && v[j]) begin
        g[j]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic set_req(input int i, input int a, input int b, input int c);
    bus.req_a[i*WD +: WD] = 4'(a);
    bus.req_b[i*WD +: WD] = 4'(b);
    bus.req_c[i*WD +: WD] = 4'(c);
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // one clock cycle: check outputs at the falling edge, then advance the model
  task automatic step();
    logic [3:0] eg;
    exp_t       e;
    int         g;
    int         av;
    int         bv;
    int         cv;
    @(negedge clk);
    eg = (rst || bus.stall) ? 4'b0000 : model_grant(bus.req_valid, ptr_m);
    check4("grant", bus.req_ready, eg);
    check1("busy", bus.busy, (inflight != 0));
    if (q.size() > 0 && q[0].due == ucnt) begin
      check4("rsp_valid", bus.rsp_valid, 4'(1 << q[0].id));
      check8("rsp_data", bus.rsp_data, q[0].data);
      last_data = q[0].data;
      if (!bus.stall) begin
        void'(q.pop_front());
        inflight--;
      end
    end else begin
      check4("rsp_idle", bus.rsp_valid, 4'b0000);
      check8("rsp_hold", bus.rsp_data, last_data);
    end
    if (eg != 4'b0000) begin
      g = 0;
      for (int i = 0; i < N; i++) if (eg[i]) g = i;
      av     = int'(bus.req_a[g*WD +: WD]);
      bv     = int'(bus.req_b[g*WD +: WD]);
      cv     = int'(bus.req_c[g*WD +: WD]);
      e.due  = ucnt + LT;
      e.id   = g;
      e.data = 8'(av * bv + cv);
      q.push_back(e);
      inflight++;
      ptr_m = (g + 1) % N;
    end
    if (!bus.stall) ucnt++;
    if (rst) begin
      q.delete();
      inflight  = 0;
      ptr_m     = 0;
      last_data = 8'd0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    ptr_m     = 0;
    inflight  = 0;
    ucnt      = 0;
    last_data = 8'd0;
    rst           = 1'b1;
    bus.stall     = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_a     = 16'd0;
    bus.req_b     = 16'd0;
    bus.req_c     = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check4("reset_ready", bus.req_ready, 4'b0000);
    check4("reset_rsp_valid", bus.rsp_valid, 4'b0000);
    check8("reset_rsp_data", bus.rsp_data, 8'd0);
    check1("reset_busy", bus.busy, 1'b0);
    step();
    rst           = 1'b0;
    bus.req_valid = 4'b0000;

    // single op from requester 0: 15*15+15 = 240
    set_req(0, 15, 15, 15);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = 4'b0000;
    repeat (5) step();

    // all four requesting continuously right after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 3, 5, 1);
    set_req(1, 7, 2, 9);
    set_req(2, 12, 11, 4);
    set_req(3, 6, 6, 15);
    bus.req_valid = 4'b1111;
    repeat (9) step();
    bus.req_valid = 4'b0000;
    repeat (5) step();

    // wrap: move pointer to 3, then 4'b1001 grants 3 then 0 back to back
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = 4'b1001;
    repeat (2) step();
    bus.req_valid = 4'b0000;
    repeat (5) step();

    // stall mid-flight with requests pending
    set_req(1, 9, 9, 2);
    set_req(2, 4, 13, 0);
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = 4'b1111;
    bus.stall     = 1'b1;
    repeat (2) step();
    bus.stall     = 1'b0;
    bus.req_valid = 4'b0000;
    repeat (6) step();

    // reset with three ops in flight, then requester 0 wins
    bus.req_valid = 4'b1110;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst           = 1'b0;
    bus.req_valid = 4'b1111;
    step();
    bus.req_valid = 4'b0000;
    repeat (5) step();

    // idle, then zero operand product
    repeat (3) step();
    set_req(3, 0, 9, 0);
    bus.req_valid = 4'b1000;
    step();
    bus.req_valid = 4'b0000;
    repeat (5) step();

    // random traffic with occasional stalls
    for (int n = 0; n < 60; n++) begin
      bus.req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      bus.stall = ($urandom_range(0, 5) == 0);
      step();
    end
    bus.stall     = 1'b0;
    bus.req_valid = 4'b0000;
    repeat (6) step();
    check1("drained_busy", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
